cmult_rr_arbiter: RTL and testbench

Shares one pipelined complex multiplier (3-stage, Q-format dequantizing) among NUM_REQ butterfly/twiddle requesters. It grants at most one operand pair per cycle using round-robin arbitration. The granted operands are registered onto the multiplier input bus, and each in-flight operation carries a requester tag through a shift pipe matched to the multiplier latency. Results are routed back to the originating requester. It sits between the FFT stage engines and the shared multiplier instance.

---
 rtl/cmult_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cmult_rr_arbiter.sv | 558 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cmult_rr_arbiter
//
// Shares one pipelined complex multiplier among NUM_REQ FFT requesters.
// At most one operand pair is granted per cycle, chosen round-robin starting
// at rr_ptr. The winner's operands are registered onto the multiplier input
// bus and its index travels down a tag pipe matched to the multiplier latency,
// so each result returned on mult_* can be steered back to its requester.
//
// Optional feature macro: CMULT_ARB_PERF_EN
//   defined   - perf_grant_cnt holds saturating 16-bit per-requester grant
//               counters, cleared by reset only.
//   undefined - perf_grant_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   arb_en            grant enable; in-flight operations drain when low
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a_*, req_w_*  packed operands, requester i at slice i
//   m_valid, m_a_*,   registered operand bus to the multiplier
//   m_w_*
//   mult_valid,       result bus from the multiplier
//   mult_real/imag
//   res_valid         one-hot result strobe, res_real/imag broadcast
//   busy              any operation in flight
//   err               sticky: mult_valid disagreed with the tag pipe tail
//   perf_grant_cnt    packed per-requester grant counters
// ---------------------------------------------------------------------------
module cmult_rr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 20,
    parameter int unsigned TWIDDLE_WIDTH = 16,
    parameter int unsigned MULT_LATENCY  = 3,
    parameter int unsigned TAG_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arb_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a_real,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a_imag,
    input  logic [NUM_REQ*TWIDDLE_WIDTH-1:0] req_w_real,
    input  logic [NUM_REQ*TWIDDLE_WIDTH-1:0] req_w_imag,
    output logic                             m_valid,
    output logic [DATA_WIDTH-1:0]            m_a_real,
    output logic [DATA_WIDTH-1:0]            m_a_imag,
    output logic [TWIDDLE_WIDTH-1:0]         m_w_real,
    output logic [TWIDDLE_WIDTH-1:0]         m_w_imag,
    input  logic                             mult_valid,
    input  logic [DATA_WIDTH-1:0]            mult_real,
    input  logic [DATA_WIDTH-1:0]            mult_imag,
    output logic [NUM_REQ-1:0]               res_valid,
    output logic [DATA_WIDTH-1:0]            res_real,
    output logic [DATA_WIDTH-1:0]            res_imag,
    output logic                             busy,
    output logic                             err,
    output logic [NUM_REQ*16-1:0]            perf_grant_cnt
);

    // -----------------------------------------------------------------------
    // Round-robin arbitration
    // -----------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] rr_ptr_q;
    logic                 grant;
    logic [TAG_WIDTH-1:0] winner;
    logic [TAG_WIDTH-1:0] ptr_next;

    always_comb begin
        int unsigned          idx;
        logic [TAG_WIDTH-1:0] idx_t;
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_t  = '0;
        if (arb_en) begin
            // Walk upward from rr_ptr with wrap; the first valid requester wins.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_t = idx[TAG_WIDTH-1:0];
                if (!grant && req_valid[idx_t]) begin
                    grant  = 1'b1;
                    winner = idx_t;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (winner == TAG_WIDTH'(i));
        end
    end

    always_comb begin
        if (winner == TAG_WIDTH'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + TAG_WIDTH'(1);
        end
    end

    // Operand select for the winner; req_ready is one-hot so at most one
    // slice is picked.
    logic [DATA_WIDTH-1:0]    sel_a_real;
    logic [DATA_WIDTH-1:0]    sel_a_imag;
    logic [TWIDDLE_WIDTH-1:0] sel_w_real;
    logic [TWIDDLE_WIDTH-1:0] sel_w_imag;

    always_comb begin
        sel_a_real = '0;
        sel_a_imag = '0;
        sel_w_real = '0;
        sel_w_imag = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_a_real = req_a_real[i*DATA_WIDTH +: DATA_WIDTH];
                sel_a_imag = req_a_imag[i*DATA_WIDTH +: DATA_WIDTH];
                sel_w_real = req_w_real[i*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
                sel_w_imag = req_w_imag[i*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issue register and pointer
    // -----------------------------------------------------------------------
    logic                     m_valid_q;
    logic [DATA_WIDTH-1:0]    m_a_real_q;
    logic [DATA_WIDTH-1:0]    m_a_imag_q;
    logic [TWIDDLE_WIDTH-1:0] m_w_real_q;
    logic [TWIDDLE_WIDTH-1:0] m_w_imag_q;
    logic [TAG_WIDTH-1:0]     issue_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            m_valid_q   <= 1'b0;
            m_a_real_q  <= '0;
            m_a_imag_q  <= '0;
            m_w_real_q  <= '0;
            m_w_imag_q  <= '0;
            issue_tag_q <= '0;
        end else begin
            m_valid_q <= grant;
            // Operand bus holds its last value between grants.
            if (grant) begin
                rr_ptr_q    <= ptr_next;
                m_a_real_q  <= sel_a_real;
                m_a_imag_q  <= sel_a_imag;
                m_w_real_q  <= sel_w_real;
                m_w_imag_q  <= sel_w_imag;
                issue_tag_q <= winner;
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_a_real = m_a_real_q;
    assign m_a_imag = m_a_imag_q;
    assign m_w_real = m_w_real_q;
    assign m_w_imag = m_w_imag_q;

    // -----------------------------------------------------------------------
    // Tag pipe: shadows the multiplier so its tail lines up with mult_valid
    // -----------------------------------------------------------------------
    logic [MULT_LATENCY-1:0] pipe_valid_q;
    logic [TAG_WIDTH-1:0]    pipe_tag_q [MULT_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= '0;
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= m_valid_q;
            pipe_tag_q[0]   <= issue_tag_q;
            for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_tag_q[i]   <= pipe_tag_q[i-1];
            end
        end
    end

    logic                 tail_valid;
    logic [TAG_WIDTH-1:0] tail_tag;

    assign tail_valid = pipe_valid_q[MULT_LATENCY-1];
    assign tail_tag   = pipe_tag_q[MULT_LATENCY-1];

    // -----------------------------------------------------------------------
    // Result register and protocol check
    // -----------------------------------------------------------------------
    logic               res_ok;
    logic               mismatch;
    logic [NUM_REQ-1:0] res_onehot;

    // A result is only delivered when the multiplier and tag pipe agree.
    assign res_ok   = mult_valid & tail_valid;
    assign mismatch = mult_valid ^ tail_valid;

    always_comb begin
        res_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            res_onehot[i] = res_ok && (tail_tag == TAG_WIDTH'(i));
        end
    end

    logic [NUM_REQ-1:0]    res_valid_q;
    logic [DATA_WIDTH-1:0] res_real_q;
    logic [DATA_WIDTH-1:0] res_imag_q;
    logic                  err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= '0;
            res_real_q  <= '0;
            res_imag_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= res_onehot;
            if (res_ok) begin
                res_real_q <= mult_real;
                res_imag_q <= mult_imag;
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_real  = res_real_q;
    assign res_imag  = res_imag_q;
    assign err       = err_q;
    assign busy      = m_valid_q | (|pipe_valid_q) | (|res_valid_q);

    // -----------------------------------------------------------------------
    // Grant counters
    // -----------------------------------------------------------------------
`ifdef CMULT_ARB_PERF_EN
    logic [15:0] perf_cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                perf_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (perf_cnt_q[i] != 16'hFFFF)) begin
                    perf_cnt_q[i] <= perf_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*16 +: 16] = perf_cnt_q[i];
        end
    end
`else
    assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cmult_rr_arbiter.sv
module tb_cmult_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 20;
    localparam int TW = 16;
    localparam int OW = 2 * DW + 2 * TW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arb_en = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a_real, req_a_imag;
    logic [N*TW-1:0]   req_w_real, req_w_imag;
    logic              m_valid;
    logic [DW-1:0]     m_a_real, m_a_imag;
    logic [TW-1:0]     m_w_real, m_w_imag;
    logic              mult_valid;
    logic [DW-1:0]     mult_real, mult_imag;
    logic [N-1:0]      res_valid;
    logic [DW-1:0]     res_real, res_imag;
    logic              busy, err;
    logic [N*16-1:0]   perf_grant_cnt;
    logic              force_mv = 1'b0;

    // Operands seen by the DUT and the staged values copied in at each negedge
    logic signed [DW-1:0] op_ar [N], op_ai [N], nx_ar [N], nx_ai [N];
    logic signed [TW-1:0] op_wr [N], op_wi [N], nx_wr [N], nx_wi [N];

    always #5 clk = ~clk;

    always_comb begin
        req_a_real = '0;
        req_a_imag = '0;
        req_w_real = '0;
        req_w_imag = '0;
        for (int i = 0; i < N; i++) begin
            req_a_real[i*DW +: DW] = op_ar[i];
            req_a_imag[i*DW +: DW] = op_ai[i];
            req_w_real[i*TW +: TW] = op_wr[i];
            req_w_imag[i*TW +: TW] = op_wi[i];
        end
    end

    cmult_rr_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arb_en         (arb_en),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a_real     (req_a_real),
        .req_a_imag     (req_a_imag),
        .req_w_real     (req_w_real),
        .req_w_imag     (req_w_imag),
        .m_valid        (m_valid),
        .m_a_real       (m_a_real),
        .m_a_imag       (m_a_imag),
        .m_w_real       (m_w_real),
        .m_w_imag       (m_w_imag),
        .mult_valid     (mult_valid),
        .mult_real      (mult_real),
        .mult_imag      (mult_imag),
        .res_valid      (res_valid),
        .res_real       (res_real),
        .res_imag       (res_imag),
        .busy           (busy),
        .err            (err),
        .perf_grant_cnt (perf_grant_cnt)
    );

    // Q14 complex product, truncated toward minus infinity
    function automatic logic [2*DW-1:0] cmul(input logic signed [DW-1:0] ar,
                                             input logic signed [DW-1:0] ai,
                                             input logic signed [TW-1:0] wr,
                                             input logic signed [TW-1:0] wi);
        longint pr;
        longint pi;
        pr = longint'(ar) * longint'(wr) - longint'(ai) * longint'(wi);
        pi = longint'(ar) * longint'(wi) + longint'(ai) * longint'(wr);
        pr = pr >>> 14;
        pi = pi >>> 14;
        return {pr[DW-1:0], pi[DW-1:0]};
    endfunction

    // Three-stage multiplier stand-in
    logic [2:0]      mv;
    logic [2*DW-1:0] md [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            mv    <= {mv[1:0], m_valid};
            md[0] <= cmul(m_a_real, m_a_imag, m_w_real, m_w_imag);
            md[1] <= md[0];
            md[2] <= md[1];
        end
    end

    assign mult_valid = mv[2] | force_mv;
    assign mult_real  = md[2][2*DW-1:DW];
    assign mult_imag  = md[2][DW-1:0];

    // ------------------------------------------------------------------
    // Reference model: rotating priority plus a queue of due results
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        int          tag;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    exp_t          sb [$];
    int            cyc = 0;
    int            ptr = 0;
    logic          err_m = 1'b0;
    logic          last_grant = 1'b0;
    logic [OW-1:0] last_ops = '0;
    int            perf_m [N];
    int            n_checks = 0;
    int            n_fail = 0;

    logic [N-1:0]    exp_ready, exp_rv, obs_ready, obs_rv;
    logic [DW-1:0]   exp_re, exp_im, obs_re, obs_im;
    logic            exp_busy, obs_busy, exp_err, obs_err, exp_mv, obs_mv;
    logic [OW-1:0]   exp_m, obs_m;
    logic [N*16-1:0] exp_perf, obs_perf;

    function automatic int pick(input logic [N-1:0] v, input logic en, input int p);
        logic [N-1:0] rot;
        int           w;
        w = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                rot = v >> ((p + k) % N);
                if (w < 0 && rot[0]) w = (p + k) % N;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        sb.delete();
        ptr        = 0;
        err_m      = 1'b0;
        last_grant = 1'b0;
        last_ops   = '0;
        for (int i = 0; i < N; i++) perf_m[i] = 0;
    endtask

    // One clock cycle: apply inputs, predict, sample DUT, advance model
    task automatic tick(input logic [N-1:0] v, input logic en, input logic fm);
        int            w;
        logic [2*DW-1:0] r;
        exp_t          e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            op_ar[i] = nx_ar[i];
            op_ai[i] = nx_ai[i];
            op_wr[i] = nx_wr[i];
            op_wi[i] = nx_wi[i];
        end
        req_valid = v;
        arb_en    = en;
        force_mv  = fm;
        #1;
        w         = pick(v, en, ptr);
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        exp_mv    = last_grant;
        exp_m     = last_ops;
        exp_busy  = 1'b0;
        foreach (sb[i]) if (sb[i].due - cyc <= 4) exp_busy = 1'b1;
        exp_rv = '0;
        exp_re = '0;
        exp_im = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv = N'(1) << sb[0].tag;
            exp_re = sb[0].re;
            exp_im = sb[0].im;
            void'(sb.pop_front());
        end
        exp_err = err_m;
`ifdef CMULT_ARB_PERF_EN
        for (int i = 0; i < N; i++) exp_perf[i*16 +: 16] = 16'(perf_m[i]);
`else
        exp_perf = '0;
`endif
        obs_ready = req_ready;
        obs_rv    = res_valid;
        obs_re    = res_real;
        obs_im    = res_imag;
        obs_busy  = busy;
        obs_err   = err;
        obs_mv    = m_valid;
        obs_m     = {m_a_real, m_a_imag, m_w_real, m_w_imag};
        obs_perf  = perf_grant_cnt;
        // A forced strobe with nothing due from the multiplier is a protocol error
        if (fm && !(sb.size() > 0 && sb[0].due == cyc + 1)) err_m = 1'b1;
        last_grant = (w >= 0);
        if (w >= 0) begin
            r     = cmul(op_ar[w], op_ai[w], op_wr[w], op_wi[w]);
            e.due = cyc + 5;
            e.tag = w;
            e.re  = r[2*DW-1:DW];
            e.im  = r[DW-1:0];
            sb.push_back(e);
            last_ops = {op_ar[w], op_ai[w], op_wr[w], op_wi[w]};
            ptr      = (w + 1) % N;
            if (perf_m[w] < 65535) perf_m[w]++;
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        arb_en    = 1'b0;
        force_mv  = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input int ar, input int ai, input int wr, input int wi);
        nx_ar[i] = DW'(ar);
        nx_ai[i] = DW'(ai);
        nx_wr[i] = TW'(wr);
        nx_wi[i] = TW'(wi);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        assert_reset();
        n_checks++;
        if ({req_ready, m_valid, res_valid, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, m_valid, res_valid, busy, err});
        end
        n_checks++;
        if ({m_a_real, m_a_imag, m_w_real, m_w_imag, res_real, res_imag} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0",
                     {m_a_real, m_a_imag, m_w_real, m_w_imag, res_real, res_imag});
        end
        n_checks++;
        if (perf_grant_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_perf got=%h exp=0", perf_grant_cnt);
        end
        release_reset();
    endtask

    task automatic test_single();
        int t0;
        int lat;
        set_op(1, 16384, 0, 16384, 0);
        tick(4'b0010, 1'b1, 1'b0);
        t0 = cyc;
        n_checks++;
        if (obs_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=0010", obs_ready);
        end
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            tick(4'b0000, 1'b1, 1'b0);
            n_checks++;
            if (obs_rv !== exp_rv) begin
                n_fail++;
                $display("FAIL single_res_valid cyc=%0d got=%b exp=%b", cyc, obs_rv, exp_rv);
            end
            if (obs_rv != 0 && lat < 0) begin
                lat = cyc - t0;
                n_checks++;
                if (obs_rv !== 4'b0010 || obs_re !== DW'(16384) || obs_im !== DW'(0)) begin
                    n_fail++;
                    $display("FAIL single_result got=%b (%0d,%0d) exp=0010 (16384,0)",
                             obs_rv, obs_re, obs_im);
                end
            end
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL single_latency got=%0d exp=5", lat);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] gnt_exp [6];
        logic [N-1:0] res_seq [6];
        int           n_res;
        gnt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        n_res   = 0;
        assert_reset();
        release_reset();
        for (int i = 0; i < N; i++) set_op(i, 1000 * (i + 1), -300 * i, 8192, -4096 * i);
        for (int i = 0; i < 14; i++) begin
            tick((i < 6) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
            if (i < 6) begin
                n_checks++;
                if (obs_ready !== gnt_exp[i]) begin
                    n_fail++;
                    $display("FAIL rr_grant idx=%0d got=%b exp=%b", i, obs_ready, gnt_exp[i]);
                end
            end
            n_checks++;
            if (obs_rv !== exp_rv || (exp_rv != 0 && {obs_re, obs_im} !== {exp_re, exp_im})) begin
                n_fail++;
                $display("FAIL rr_result cyc=%0d got=%b %h exp=%b %h",
                         cyc, obs_rv, {obs_re, obs_im}, exp_rv, {exp_re, exp_im});
            end
            if (obs_rv != 0 && n_res < 6) begin
                res_seq[n_res] = obs_rv;
                n_res++;
            end
        end
        n_checks++;
        if (n_res !== 6 || res_seq !== gnt_exp) begin
            n_fail++;
            $display("FAIL rr_result_order count=%0d exp=6", n_res);
        end
    endtask

    task automatic test_ptr_skip();
        logic seen;
        seen = 1'b0;
        set_op(2, 100, -50, 8192, 8192);
        tick(4'b0001, 1'b1, 1'b0);
        tick(4'b0101, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL ptr_first got=%b exp=0100", obs_ready);
        end
        tick(4'b0001, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL ptr_second got=%b exp=0001", obs_ready);
        end
        for (int i = 0; i < 7; i++) begin
            tick(4'b0000, 1'b1, 1'b0);
            n_checks++;
            if (obs_rv !== exp_rv) begin
                n_fail++;
                $display("FAIL ptr_res_valid cyc=%0d got=%b exp=%b", cyc, obs_rv, exp_rv);
            end
            if (obs_rv == 4'b0100) begin
                seen = 1'b1;
                n_checks++;
                if (obs_re !== DW'(75) || obs_im !== DW'(25)) begin
                    n_fail++;
                    $display("FAIL ptr_result got=(%0d,%0d) exp=(75,25)",
                             $signed(obs_re), $signed(obs_im));
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ptr_result_missing got=none exp=res_valid 0100");
        end
    endtask

    task automatic test_arb_en_drain();
        for (int i = 0; i < N; i++) begin
            set_op(i, int'($urandom_range(0, 200000)) - 100000, 77 * i, 12000, -9000);
        end
        repeat (3) tick(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(4'b1111, 1'b0, 1'b0);
            n_checks++;
            if (obs_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL drain_ready cyc=%0d got=%b exp=0000", cyc, obs_ready);
            end
            n_checks++;
            if (obs_mv !== exp_mv || (i > 0 && obs_mv !== 1'b0)) begin
                n_fail++;
                $display("FAIL drain_m_valid cyc=%0d got=%b exp=%b", cyc, obs_mv, exp_mv);
            end
            n_checks++;
            if (obs_rv !== exp_rv || (exp_rv != 0 && {obs_re, obs_im} !== {exp_re, exp_im})) begin
                n_fail++;
                $display("FAIL drain_result cyc=%0d got=%b %h exp=%b %h",
                         cyc, obs_rv, {obs_re, obs_im}, exp_rv, {exp_re, exp_im});
            end
            n_checks++;
            if (obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL drain_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy);
            end
        end
        n_checks++;
        if (obs_busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_idle got busy=%b pending=%0d exp busy=0 pending=0",
                     obs_busy, sb.size());
        end
    endtask

    task automatic test_err();
        tick(4'b0000, 1'b1, 1'b1);
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early got=%b exp=0", obs_err);
        end
        for (int i = 0; i < 4; i++) begin
            tick(4'b0000, 1'b1, 1'b0);
            n_checks++;
            if (obs_err !== 1'b1 || obs_err !== exp_err) begin
                n_fail++;
                $display("FAIL err_sticky cyc=%0d got=%b exp=1", cyc, obs_err);
            end
            n_checks++;
            if (obs_rv !== 4'b0000) begin
                n_fail++;
                $display("FAIL err_res_valid cyc=%0d got=%b exp=0000", cyc, obs_rv);
            end
        end
    endtask

    task automatic test_reset_midflight();
        repeat (3) tick(4'b1111, 1'b1, 1'b0);
        assert_reset();
        n_checks++;
        if ({m_valid, res_valid, busy, err, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear got=%b exp=0", {m_valid, res_valid, busy, err, req_ready});
        end
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick(4'b0000, 1'b1, 1'b0);
            n_checks++;
            if (obs_rv !== 4'b0000 || obs_err !== 1'b0 || obs_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stray cyc=%0d got rv=%b err=%b busy=%b exp 0 0 0",
                         cyc, obs_rv, obs_err, obs_busy);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] v;
        logic         en;
        pend = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    nx_ar[i] = DW'($urandom);
                    nx_ai[i] = DW'($urandom);
                    nx_wr[i] = TW'($urandom);
                    nx_wi[i] = TW'($urandom);
                    pend[i]  = ($urandom_range(0, 2) != 0);
                end
            end
            v  = (t < 390) ? pend : '0;
            en = ($urandom_range(0, 7) != 0);
            tick(v, en, 1'b0);
            pend = v & ~exp_ready;
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready);
            end
            n_checks++;
            if (obs_rv !== exp_rv || (exp_rv != 0 && {obs_re, obs_im} !== {exp_re, exp_im})) begin
                n_fail++;
                $display("FAIL rand_result cyc=%0d got=%b %h exp=%b %h",
                         cyc, obs_rv, {obs_re, obs_im}, exp_rv, {exp_re, exp_im});
            end
            n_checks++;
            if (obs_mv !== exp_mv || (exp_mv && obs_m !== exp_m)) begin
                n_fail++;
                $display("FAIL rand_issue cyc=%0d got=%b %h exp=%b %h",
                         cyc, obs_mv, obs_m, exp_mv, exp_m);
            end
            n_checks++;
            if (obs_busy !== exp_busy || obs_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand_status cyc=%0d got busy=%b err=%b exp busy=%b err=%b",
                         cyc, obs_busy, obs_err, exp_busy, exp_err);
            end
        end
    endtask

    task automatic test_perf();
        assert_reset();
        release_reset();
        set_op(0, 5000, 1, 16384, 0);
`ifdef CMULT_ARB_PERF_EN
        for (int i = 0; i < 70000; i++) begin
            tick(4'b0001, 1'b1, 1'b0);
            n_checks++;
            if (obs_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL perf_grant cyc=%0d got=%b exp=0001", cyc, obs_ready);
            end
            if (i == 65534 || i == 65535) begin
                n_checks++;
                if (obs_perf !== exp_perf) begin
                    n_fail++;
                    $display("FAIL perf_count idx=%0d got=%h exp=%h", i, obs_perf, exp_perf);
                end
            end
        end
        tick(4'b0000, 1'b1, 1'b0);
        n_checks++;
        if (obs_perf[15:0] !== 16'hFFFF || obs_perf !== exp_perf) begin
            n_fail++;
            $display("FAIL perf_saturate got=%h exp=%h", obs_perf, exp_perf);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick(4'b1111, 1'b1, 1'b0);
            n_checks++;
            if (obs_perf !== '0) begin
                n_fail++;
                $display("FAIL perf_tied got=%h exp=0", obs_perf);
            end
        end
`endif
        repeat (6) tick(4'b0000, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            set_op(i, 0, 0, 0, 0);
            op_ar[i] = '0;
            op_ai[i] = '0;
            op_wr[i] = '0;
            op_wi[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_skip();
        test_arb_en_drain();
        test_err();
        test_reset_midflight();
        test_random();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
